// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 Booth steps over operands extended by one bit,
// giving an exact 2*WIDTH-bit product in both signed and unsigned modes.
module booth_multiplier_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   q_reg;
    logic             q_m1;
    logic [WIDTH+1:0] a;
    logic [CW-1:0]    count;

    logic [WIDTH+1:0]   m_sxt;
    logic [WIDTH+1:0]   a_sum;
    logic [2*WIDTH+4:0] cat;
    logic [WIDTH+1:0]   a_step;
    logic [WIDTH:0]     q_step;
    logic               qm1_step;
    logic               mc_ext_bit;
    logic               mp_ext_bit;

    always_comb begin
        m_sxt = {m_ext[WIDTH], m_ext};
        case ({q_reg[0], q_m1})
            2'b01:   a_sum = a + m_sxt;
            2'b10:   a_sum = a - m_sxt;
            default: a_sum = a;
        endcase
        // Arithmetic right shift of {A, Q, Q-1} with A's MSB replicated.
        cat      = {a_sum[WIDTH+1], a_sum, q_reg, q_m1};
        a_step   = cat[2*WIDTH+4:WIDTH+3];
        q_step   = cat[WIDTH+2:2];
        qm1_step = cat[1];
    end

    assign mc_ext_bit = signed_mode & multiplicand[WIDTH-1];
    assign mp_ext_bit = signed_mode & multiplier[WIDTH-1];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            m_ext   <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            a       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        m_ext <= {mc_ext_bit, multiplicand};
                        q_reg <= {mp_ext_bit, multiplier};
                        q_m1  <= 1'b0;
                        a     <= '0;
                        count <= STEPS;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a     <= a_step;
                    q_reg <= q_step;
                    q_m1  <= qm1_step;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state   <= DONE;
                        product <= {a_step[WIDTH-2:0], q_step};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed bench for booth_multiplier_seq: an 8-bit instance for arithmetic and timing,
// a 16-bit instance for asynchronous reset mid-operation.
module tb_booth_multiplier_seq;

    logic        clock;
    logic        reset;

    logic        start8, sm8;
    logic [7:0]  mc8, mp8;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start16, sm16;
    logic [15:0] mc16, mp16;
    logic        busy16, done16;
    logic [31:0] prod16;

    int passed;
    int total;

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .signed_mode (sm8),
        .multiplicand(mc8),
        .multiplier  (mp8),
        .busy        (busy8),
        .done        (done8),
        .product     (prod8)
    );

    booth_multiplier_seq #(.WIDTH(16)) dut16 (
        .clock       (clock),
        .reset       (reset),
        .start       (start16),
        .signed_mode (sm16),
        .multiplicand(mc16),
        .multiplier  (mp16),
        .busy        (busy16),
        .done        (done16),
        .product     (prod16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns 1ns after the accepting edge with start already dropped.
    task automatic issue8(input logic sm, input logic [7:0] mc, input logic [7:0] mp);
        @(negedge clock);
        sm8 = sm; mc8 = mc; mp8 = mp; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic sm, input logic [15:0] mc, input logic [15:0] mp);
        @(negedge clock);
        sm16 = sm; mc16 = mc; mp16 = mp; start16 = 1'b1;
        @(posedge clock);
        #1;
        start16 = 1'b0;
    endtask

    // Counts edges until done is seen; busy cycles include the sample taken before the call.
    task automatic wait_done8(output int lat, output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (done8) seen = 1'b1;
            else if (busy8) busy_cnt++;
        end
        if (!seen) lat = -1;
    endtask

    task automatic wait_done16(output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (done16) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({busy8, done8, prod8} !== 18'd0) $display("FAIL reset8 got %h want 0", {busy8, done8, prod8});
        else passed++;
        total++;
        if ({busy16, done16, prod16} !== 34'd0)
            $display("FAIL reset16 got %h want 0", {busy16, done16, prod16});
        else passed++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_signed_small();
        int lat, bc;
        issue8(1'b1, 8'hFD, 8'd5);
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'hFFF1) $display("FAIL neg3x5_product got %h want fff1", prod8);
        else passed++;
        total++;
        if (lat != 9) $display("FAIL neg3x5_latency got %0d want 9", lat);
        else passed++;
        total++;
        if (bc != 9) $display("FAIL neg3x5_busy_cycles got %0d want 9", bc);
        else passed++;
        @(posedge clock);
        #1;
        total++;
        if ({done8, busy8} !== 2'b00) $display("FAIL neg3x5_single_done got %b want 00", {done8, busy8});
        else passed++;
        total++;
        if (prod8 !== 16'hFFF1) $display("FAIL neg3x5_held got %h want fff1", prod8);
        else passed++;
    endtask

    task automatic test_corners();
        int lat, bc;
        issue8(1'b1, 8'h80, 8'h80);
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'h4000 || lat != 9)
            $display("FAIL min_x_min got %h lat %0d want 4000 lat 9", prod8, lat);
        else passed++;
        issue8(1'b0, 8'hFF, 8'hFF);
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'hFE01 || lat != 9)
            $display("FAIL u255_x_255 got %h lat %0d want fe01 lat 9", prod8, lat);
        else passed++;
        issue8(1'b1, 8'h7F, 8'h80);
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'hC080 || lat != 9)
            $display("FAIL max_x_min got %h lat %0d want c080 lat 9", prod8, lat);
        else passed++;
        // Same bit patterns read as unsigned: 253 * 5 = 1265
        issue8(1'b0, 8'hFD, 8'd5);
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'h04F1) $display("FAIL u253x5 got %h want 04f1", prod8);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue8(1'b0, 8'd10, 8'd20);
        @(negedge clock);
        sm8 = 1'b1; mc8 = 8'd3; mp8 = 8'd3; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1) $display("FAIL run_start_busy got %b want 1", busy8);
        else passed++;
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'h00C8 || lat != 8)
            $display("FAIL run_start_ignored got %h lat %0d want 00c8 lat 8", prod8, lat);
        else passed++;
        // Request the next operation while in DONE
        sm8 = 1'b0; mc8 = 8'd6; mp8 = 8'd7; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        total++;
        if ({done8, busy8} !== 2'b01) $display("FAIL b2b_handover got %b want 01", {done8, busy8});
        else passed++;
        total++;
        if (prod8 !== 16'h00C8) $display("FAIL b2b_prev_held got %h want 00c8", prod8);
        else passed++;
        wait_done8(lat, bc);
        total++;
        if (prod8 !== 16'h002A || lat != 9)
            $display("FAIL b2b_second got %h lat %0d want 002a lat 9", prod8, lat);
        else passed++;
        @(posedge clock);
        #1;
        total++;
        if (done8 !== 1'b0) $display("FAIL b2b_single_done got %b want 0", done8);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int pulses;
        issue16(1'b0, 16'd300, 16'd7);
        wait_done16(lat);
        total++;
        if (prod16 !== 32'h0000_0834 || lat != 17)
            $display("FAIL w16_first got %h lat %0d want 00000834 lat 17", prod16, lat);
        else passed++;
        issue16(1'b0, 16'd1234, 16'd5678);
        repeat (5) @(posedge clock);
        #3;
        total++;
        if (busy16 !== 1'b1) $display("FAIL w16_busy_before_reset got %b want 1", busy16);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({busy16, done16, prod16} !== 34'd0)
            $display("FAIL w16_async_reset got %h want 0", {busy16, done16, prod16});
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            if (done16 || busy16) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL w16_no_done_after_reset got %0d want 0", pulses);
        else passed++;
        issue16(1'b0, 16'd1000, 16'd1000);
        wait_done16(lat);
        total++;
        if (prod16 !== 32'h000F_4240 || lat != 17)
            $display("FAIL w16_1000sq got %h lat %0d want 000f4240 lat 17", prod16, lat);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        start8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
        start16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
        test_reset();
        test_signed_small();
        test_corners();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
